// File: rtl/time_counter_dp_pkg.sv
// Shared field moduli, widths and the default prescaler length for the
// timekeeping datapath.
package time_counter_dp_pkg;

  localparam int MSEC_MOD = 100;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  // 100 MHz / 100 Hz
  localparam int F_COUNT_DEFAULT = 1_000_000;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter with carry-producing increment, no-carry manual increment
// and a load value shared by reset and synchronous clear.
module mod_n_counter #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         i_inc,
  input  logic         i_up,
  input  logic [W-1:0] i_load,
  output logic [W-1:0] count,
  output logic         o_carry
);

  logic at_max;

  assign at_max  = (count == W'(N - 1));
  assign o_carry = i_inc && at_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= i_load;
    end else if (clear) begin
      count <= i_load;
    end else if (i_inc || i_up) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/time_counter_dp.sv
// Timekeeping datapath: 10 ms prescaler feeding a msec/sec/min/hour cascade,
// with run/stop, synchronous clear and per-field time-set while stopped.
module time_counter_dp
  import time_counter_dp_pkg::*;
#(
  parameter int F_COUNT   = F_COUNT_DEFAULT,
  parameter int INIT_HOUR = 0,
  parameter int INIT_MIN  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic              i_clear,
  input  logic              i_sec_up,
  input  logic              i_min_up,
  input  logic              i_hour_up,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);

  localparam int PW = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;

  logic [PW-1:0] presc;
  logic          presc_at_end;
  logic          tick_d;
  logic          tick;
  logic          set_en;
  logic          msec_carry, sec_carry, min_carry, hour_carry_unused;

  assign presc_at_end = (presc == PW'(F_COUNT - 1));
  assign tick_d       = i_run && !i_clear && presc_at_end;
  assign set_en       = !i_run;

  // Prescaler only advances while running, so stop/resume keeps its phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= tick_d;
      if (i_clear) begin
        presc <= '0;
      end else if (i_run) begin
        presc <= presc_at_end ? '0 : presc + PW'(1);
      end
    end
  end

  assign o_tick = tick;

  mod_n_counter #(.N(MSEC_MOD), .W(MSEC_W)) u_msec (
    .clk     (clk),
    .reset   (reset),
    .clear   (i_clear),
    .i_inc   (tick_d),
    .i_up    (1'b0),
    .i_load  ('0),
    .count   (o_msec),
    .o_carry (msec_carry)
  );

  mod_n_counter #(.N(SEC_MOD), .W(SEC_W)) u_sec (
    .clk     (clk),
    .reset   (reset),
    .clear   (i_clear),
    .i_inc   (msec_carry),
    .i_up    (set_en && i_sec_up),
    .i_load  ('0),
    .count   (o_sec),
    .o_carry (sec_carry)
  );

  mod_n_counter #(.N(MIN_MOD), .W(MIN_W)) u_min (
    .clk     (clk),
    .reset   (reset),
    .clear   (i_clear),
    .i_inc   (sec_carry),
    .i_up    (set_en && i_min_up),
    .i_load  (MIN_W'(INIT_MIN)),
    .count   (o_min),
    .o_carry (min_carry)
  );

  // Hour wraps 23 -> 0 with nothing above it to carry into.
  mod_n_counter #(.N(HOUR_MOD), .W(HOUR_W)) u_hour (
    .clk     (clk),
    .reset   (reset),
    .clear   (i_clear),
    .i_inc   (min_carry),
    .i_up    (set_en && i_hour_up),
    .i_load  (HOUR_W'(INIT_HOUR)),
    .count   (o_hour),
    .o_carry (hour_carry_unused)
  );

endmodule

// File: tb/tb_time_counter_dp.sv
// Self-checking bench for time_counter_dp: directed scenarios plus random
// run/clear/set traffic against a linear elapsed-time reference model.
module tb_time_counter_dp;

  localparam int F   = 4;
  localparam int IH  = 7;
  localparam int IM  = 42;
  localparam int DAY = 24 * 60 * 60 * 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, clr = 1'b0, su = 1'b0, mu = 1'b0, hu = 1'b0;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;

  int errors = 0;
  int checks = 0;
  int m_t, m_ph, m_tick;

  time_counter_dp #(.F_COUNT(F), .INIT_HOUR(IH), .INIT_MIN(IM)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_run     (run),
    .i_clear   (clr),
    .i_sec_up  (su),
    .i_min_up  (mu),
    .i_hour_up (hu),
    .o_msec    (o_msec),
    .o_sec     (o_sec),
    .o_min     (o_min),
    .o_hour    (o_hour),
    .o_tick    (o_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int compose(input int ms, input int s, input int m, input int h);
    return ((h * 60 + m) * 60 + s) * 100 + ms;
  endfunction

  task automatic model_reset();
    m_t    = compose(0, 0, IM, IH);
    m_ph   = 0;
    m_tick = 0;
  endtask

  // Reference: time is one integer count of 10 ms units since midnight.
  task automatic model_step();
    int ms, s, m, h;
    ms = m_t % 100;
    s  = (m_t / 100) % 60;
    m  = (m_t / 6000) % 60;
    h  = m_t / 360000;
    m_tick = 0;
    if (clr) begin
      m_t  = compose(0, 0, IM, IH);
      m_ph = 0;
    end else if (run) begin
      if (m_ph == F - 1) begin
        m_ph   = 0;
        m_t    = (m_t + 1) % DAY;
        m_tick = 1;
      end else begin
        m_ph++;
      end
    end else begin
      if (su) s = (s + 1) % 60;
      if (mu) m = (m + 1) % 60;
      if (hu) h = (h + 1) % 24;
      m_t = compose(ms, s, m, h);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("msec", int'(o_msec), m_t % 100);
    chk("sec",  int'(o_sec),  (m_t / 100) % 60);
    chk("min",  int'(o_min),  (m_t / 6000) % 60);
    chk("hour", int'(o_hour), m_t / 360000);
    chk("tick", int'(o_tick), m_tick);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (o_tick !== 1'b1 && n < 64);
    if (o_tick !== 1'b1) chk("tick_timeout", int'(o_tick), 1);
  endtask

  function automatic int field(input int f);
    case (f)
      0:       return int'(o_sec);
      1:       return int'(o_min);
      default: return int'(o_hour);
    endcase
  endfunction

  task automatic bump(input int f, input int target);
    for (int i = 0; i < 80 && field(f) != target; i++) begin
      su = (f == 0);
      mu = (f == 1);
      hu = (f == 2);
      cycle();
      su = 1'b0; mu = 1'b0; hu = 1'b0;
    end
    chk("bump", field(f), target);
  endtask

  task automatic run_to_msec99();
    for (int i = 0; i < 600 && !(o_tick === 1'b1 && o_msec == 7'd99); i++) cycle();
    chk("reach_99", int'(o_msec), 99);
  endtask

  initial begin
    int n, ms0, m0;
    model_reset();
    #12 reset = 1'b0;
    chk("rst_msec", int'(o_msec), 0);
    chk("rst_sec",  int'(o_sec),  0);
    chk("rst_min",  int'(o_min),  IM);
    chk("rst_hour", int'(o_hour), IH);
    chk("rst_tick", int'(o_tick), 0);

    // Reset mid-count at msec 37, then first tick latency.
    run = 1'b1;
    for (int i = 0; i < 400 && o_msec != 7'd37; i++) cycle();
    chk("t1_reach", int'(o_msec), 37);
    #2 reset = 1'b1;
    #1;
    chk("t1_msec", int'(o_msec), 0);
    chk("t1_sec",  int'(o_sec),  0);
    chk("t1_min",  int'(o_min),  IM);
    chk("t1_hour", int'(o_hour), IH);
    chk("t1_tick", int'(o_tick), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    wait_tick(n);
    chk("t1_lat", n, 4);
    chk("t1_msec1", int'(o_msec), 1);

    // Random run/stop, clear and time-set traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) run = ~run;
      clr = ($urandom_range(63) == 0);
      su  = ($urandom_range(3) == 0);
      mu  = ($urandom_range(3) == 0);
      hu  = ($urandom_range(3) == 0);
      cycle();
    end
    clr = 1'b0; su = 1'b0; mu = 1'b0; hu = 1'b0;

    // Full-day rollover 23:59:59.99 -> 00:00:00.00.
    run = 1'b0;
    clr = 1'b1; cycle(); clr = 1'b0;
    bump(2, 23); bump(1, 59); bump(0, 59);
    run = 1'b1;
    run_to_msec99();
    chk("t2_sec",  int'(o_sec),  59);
    chk("t2_min",  int'(o_min),  59);
    chk("t2_hour", int'(o_hour), 23);
    wait_tick(n);
    chk("t2_msec0", int'(o_msec), 0);
    chk("t2_sec0",  int'(o_sec),  0);
    chk("t2_min0",  int'(o_min),  0);
    chk("t2_hour0", int'(o_hour), 0);
    chk("t2_tick",  int'(o_tick), 1);

    // 61 second-ups while stopped; min-up ignored while running.
    run = 1'b0;
    m0 = int'(o_min);
    ms0 = int'(o_msec);
    repeat (61) begin
      su = 1'b1; cycle(); su = 1'b0; cycle();
    end
    chk("t3_sec",  int'(o_sec),  1);
    chk("t3_min",  int'(o_min),  m0);
    chk("t3_msec", int'(o_msec), ms0);
    run = 1'b1;
    mu = 1'b1; cycle(); mu = 1'b0;
    cycle();
    chk("t3_min_run", int'(o_min), m0);

    // Stop for 10 cycles with prescaler at 2; phase must be preserved.
    wait_tick(n);
    cycle(); cycle();
    ms0 = int'(o_msec);
    run = 1'b0;
    repeat (10) begin
      cycle();
      chk("t4_hold_tick", int'(o_tick), 0);
    end
    chk("t4_hold_msec", int'(o_msec), ms0);
    run = 1'b1;
    wait_tick(n);
    chk("t4_lat", n, 2);
    chk("t4_msec", int'(o_msec), (ms0 + 1) % 100);

    // Clear on the cycle a tick would fire, at msec 99 / sec 5.
    run = 1'b0;
    clr = 1'b1; cycle(); clr = 1'b0;
    bump(0, 5);
    run = 1'b1;
    run_to_msec99();
    chk("t5_sec5", int'(o_sec), 5);
    cycle(); cycle(); cycle();
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("t5_msec", int'(o_msec), 0);
    chk("t5_sec",  int'(o_sec),  0);
    chk("t5_tick", int'(o_tick), 0);
    wait_tick(n);
    chk("t5_lat", n, 4);
    chk("t5_msec1", int'(o_msec), 1);

    // Simultaneous ups from 23:59:59 wrap each field without carry.
    run = 1'b0;
    bump(2, 23); bump(1, 59); bump(0, 59);
    ms0 = int'(o_msec);
    su = 1'b1; mu = 1'b1; hu = 1'b1;
    cycle();
    su = 1'b0; mu = 1'b0; hu = 1'b0;
    chk("t6_sec",  int'(o_sec),  0);
    chk("t6_min",  int'(o_min),  0);
    chk("t6_hour", int'(o_hour), 0);
    chk("t6_msec", int'(o_msec), ms0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
